// File: rtl/btn_event_sched.sv
// Per-button press / auto-repeat event generator feeding a single valid/ready
// event port through one-deep pending slots and a round-robin arbiter.
module btn_event_sched #(
  parameter int DELAY  = 50_000_000,
  parameter int PERIOD = 10_000_000,
  parameter int CW     = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_level,
  input  logic [3:0] btn_press,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_id,
  output logic       ev_repeat,
  output logic [7:0] drop_cnt
);

  localparam longint CAP   = (CW >= 40) ? (longint'(1) << 40) : (longint'(1) << CW);
  localparam longint MAXDP = (DELAY > PERIOD) ? longint'(DELAY) : longint'(PERIOD);

  if (DELAY < 2 || PERIOD < 2 || CW < 1 || MAXDP > CAP) begin : g_param_error
    $error("btn_event_sched: need DELAY>=2, PERIOD>=2 and max(DELAY,PERIOD) <= 2**CW");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [3:0] gen;
  logic [3:0] gen_rep;
  logic [3:0] pend;
  logic [3:0] pend_rep;
  logic [3:0] drain;
  logic [3:0] drop;
  logic       load;
  logic       found;
  logic [1:0] winner;
  logic [1:0] rr_idx;
  logic [1:0] last_grant;
  logic [2:0] drop_sum;
  logic [8:0] drop_total;

  assign load = ~ev_valid | ev_ready;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          gen_b;
    logic          gen_rep_b;
    logic          pend_b;
    logic          pend_rep_b;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    // A press restarts the hold timer from any state; release beats a due repeat.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      gen_b      = 1'b0;
      gen_rep_b  = 1'b0;
      if (btn_press[gi]) begin
        state_next = WAIT;
        cnt_next   = '0;
        gen_b      = 1'b1;
      end else begin
        case (state)
          WAIT: begin
            if (!btn_level[gi]) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt == CW'(DELAY - 1)) begin
              gen_b      = 1'b1;
              gen_rep_b  = 1'b1;
              state_next = REPEAT;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
          REPEAT: begin
            if (!btn_level[gi]) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt == CW'(PERIOD - 1)) begin
              gen_b     = 1'b1;
              gen_rep_b = 1'b1;
              cnt_next  = '0;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    // An occupied slot that is not draining this cycle keeps its old event.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_b     <= 1'b0;
        pend_rep_b <= 1'b0;
      end else if (gen_b && !(pend_b && !drain[gi])) begin
        pend_b     <= 1'b1;
        pend_rep_b <= gen_rep_b;
      end else if (drain[gi]) begin
        pend_b <= 1'b0;
      end
    end

    assign gen[gi]      = gen_b;
    assign gen_rep[gi]  = gen_rep_b;
    assign pend[gi]     = pend_b;
    assign pend_rep[gi] = pend_rep_b;
    assign drain[gi]    = load & found & (winner == 2'(gi));
    assign drop[gi]     = gen_b & pend_b & ~drain[gi];
  end

  // Scan downward so the nearest candidate after last_grant is the final write.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    rr_idx = '0;
    for (int k = 4; k >= 1; k--) begin
      rr_idx = last_grant + 2'(k);
      if (pend[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid   <= 1'b0;
      ev_id      <= 2'd0;
      ev_repeat  <= 1'b0;
      last_grant <= 2'd3;
    end else if (load) begin
      if (found) begin
        ev_valid   <= 1'b1;
        ev_id      <= winner;
        ev_repeat  <= pend_rep[winner];
        last_grant <= winner;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    drop_sum   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    drop_total = {1'b0, drop_cnt} + {6'd0, drop_sum};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else begin
      drop_cnt <= (drop_total > 9'd255) ? 8'hFF : drop_total[7:0];
    end
  end

endmodule

// File: tb/tb_btn_event_sched.sv
// Directed bench for btn_event_sched with DELAY=8, PERIOD=4; "cycle t" is the
// interval after a posedge, inputs are driven and outputs checked 1 time unit in.
module tb_btn_event_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_level = 4'd0;
  logic [3:0] btn_press = 4'd0;
  logic       ev_ready = 1'b1;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_repeat;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_v;

  always #5 clk = ~clk;

  btn_event_sched #(.DELAY(8), .PERIOD(4), .CW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_id     (ev_id),
    .ev_repeat (ev_repeat),
    .drop_cnt  (drop_cnt)
  );

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready)
      $display("xfer t=%0t id=%0d rep=%0d drop_cnt=%0d", $time, ev_id, ev_repeat, drop_cnt);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input logic v, input logic [1:0] id, input logic rep);
    chk({tag, ".valid"}, {7'd0, ev_valid}, {7'd0, v});
    if (v) begin
      chk({tag, ".id"}, {6'd0, ev_id}, {6'd0, id});
      chk({tag, ".rep"}, {7'd0, ev_repeat}, {7'd0, rep});
    end
  endtask

  // Leaves the bench in cycle 0 of a fresh run with reset released.
  task automatic do_reset();
    rst       = 1'b1;
    btn_press = 4'd0;
    btn_level = 4'd0;
    ev_ready  = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst.valid", {7'd0, ev_valid}, 8'd0);
    chk("rst.id", {6'd0, ev_id}, 8'd0);
    chk("rst.rep", {7'd0, ev_repeat}, 8'd0);
    chk("rst.drop", drop_cnt, 8'd0);

    // Press then hold button 0: initial event plus three repeats, none after release.
    do_reset();
    btn_press = 4'b0001;
    chk_ev("A.c0", 1'b0, 2'd0, 1'b0);
    for (int t = 1; t <= 25; t++) begin
      cyc();
      btn_press = 4'b0000;
      btn_level = (t <= 19) ? 4'b0001 : 4'b0000;
      exp_v = (t == 2 || t == 10 || t == 14 || t == 18);
      chk_ev($sformatf("A.c%0d", t), exp_v, 2'd0, (t != 2));
    end
    btn_level = 4'd0;

    // Simultaneous presses on buttons 0 and 2.
    do_reset();
    btn_press = 4'b0101;
    cyc();
    btn_press = 4'b0000;
    chk_ev("B.c1", 1'b0, 2'd0, 1'b0);
    cyc();
    chk_ev("B.c2", 1'b1, 2'd0, 1'b0);
    cyc();
    chk_ev("B.c3", 1'b1, 2'd2, 1'b0);
    cyc();
    chk_ev("B.c4", 1'b0, 2'd0, 1'b0);

    // Stalled output: second press pends, third is dropped.
    do_reset();
    ev_ready  = 1'b0;
    btn_press = 4'b0010;
    cyc();
    btn_press = 4'b0000;
    cyc();
    chk_ev("C.c2", 1'b1, 2'd1, 1'b0);
    cyc();
    btn_press = 4'b0010;
    chk_ev("C.c3", 1'b1, 2'd1, 1'b0);
    cyc();
    btn_press = 4'b0000;
    chk_ev("C.c4", 1'b1, 2'd1, 1'b0);
    cyc();
    btn_press = 4'b0010;
    chk("C.c5.drop", drop_cnt, 8'd0);
    cyc();
    btn_press = 4'b0000;
    chk_ev("C.c6", 1'b1, 2'd1, 1'b0);
    chk("C.c6.drop", drop_cnt, 8'd1);
    cyc();
    ev_ready = 1'b1;
    chk_ev("C.c7", 1'b1, 2'd1, 1'b0);
    cyc();
    chk_ev("C.c8", 1'b1, 2'd1, 1'b0);
    cyc();
    chk_ev("C.c9", 1'b0, 2'd0, 1'b0);
    chk("C.c9.drop", drop_cnt, 8'd1);

    // Round-robin order after a grant to button 3.
    do_reset();
    ev_ready  = 1'b0;
    btn_press = 4'b1000;
    cyc();
    btn_press = 4'b0000;
    cyc();
    chk_ev("D.c2", 1'b1, 2'd3, 1'b0);
    btn_press = 4'b1011;
    cyc();
    btn_press = 4'b0000;
    chk_ev("D.c3", 1'b1, 2'd3, 1'b0);
    cyc();
    ev_ready = 1'b1;
    chk_ev("D.c4", 1'b1, 2'd3, 1'b0);
    cyc();
    chk_ev("D.c5", 1'b1, 2'd0, 1'b0);
    cyc();
    chk_ev("D.c6", 1'b1, 2'd1, 1'b0);
    cyc();
    chk_ev("D.c7", 1'b1, 2'd3, 1'b0);
    ev_ready  = 1'b0;
    btn_press = 4'b0010;
    cyc();
    btn_press = 4'b0001;
    chk_ev("D.c8", 1'b1, 2'd3, 1'b0);
    cyc();
    btn_press = 4'b0000;
    ev_ready  = 1'b1;
    chk_ev("D.c9", 1'b1, 2'd3, 1'b0);
    cyc();
    chk_ev("D.c10", 1'b1, 2'd0, 1'b0);
    cyc();
    chk_ev("D.c11", 1'b1, 2'd1, 1'b0);
    cyc();
    chk_ev("D.c12", 1'b0, 2'd0, 1'b0);
    chk("D.c12.drop", drop_cnt, 8'd0);

    // Asynchronous reset while repeating with a stalled output and 5 drops.
    do_reset();
    ev_ready  = 1'b0;
    btn_press = 4'b0001;
    for (int t = 1; t <= 29; t++) begin
      cyc();
      btn_press = 4'b0000;
      btn_level = 4'b0001;
      if (t == 28) chk("E.c28.drop", drop_cnt, 8'd4);
    end
    chk_ev("E.c29", 1'b1, 2'd0, 1'b0);
    chk("E.c29.drop", drop_cnt, 8'd5);
    #1;
    rst = 1'b1;
    #1;
    chk("E.async.valid", {7'd0, ev_valid}, 8'd0);
    chk("E.async.drop", drop_cnt, 8'd0);
    chk("E.async.id", {6'd0, ev_id}, 8'd0);
    rst      = 1'b0;
    ev_ready = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      cyc();
      chk($sformatf("E.post%0d.valid", t), {7'd0, ev_valid}, 8'd0);
    end
    chk("E.post.drop", drop_cnt, 8'd0);
    btn_level = 4'd0;

    // Continuous presses on all buttons into a stalled output: drop_cnt saturates.
    do_reset();
    ev_ready  = 1'b0;
    btn_press = 4'b1111;
    for (int n = 1; n <= 78; n++) begin
      cyc();
      if (n == 2)  chk("F.c2.drop", drop_cnt, 8'd3);
      if (n == 10) chk("F.c10.drop", drop_cnt, 8'd35);
      if (n == 64) chk("F.c64.drop", drop_cnt, 8'd251);
      if (n == 65) chk("F.c65.drop", drop_cnt, 8'd255);
      if (n == 78) chk("F.c78.drop", drop_cnt, 8'd255);
    end
    btn_press = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_event_sched.md
BTN_EVENT_SCHED -- requirements
Module: btn_event_sched

Interface
REQ-001 SHALL have parameter DELAY, default 50_000_000, meaning cycles held before the first auto-repeat (500 ms at 100 MHz).
REQ-002 SHALL have parameter PERIOD, default 10_000_000, meaning cycles between auto-repeats (100 ms at 100 MHz).
REQ-003 SHALL have parameter CW, default 26, meaning hold-counter width; a violation of DELAY >= 2, PERIOD >= 2 or max(DELAY,PERIOD) <= 2^CW SHALL be an elaboration error.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single system clock; all flops on posedge.
REQ-005 SHALL have port rst, input, 1 bit, meaning reset: asynchronous, active-high.
REQ-006 SHALL have port btn_level, input, 4 bits, meaning debounced button levels, 1 = held.
REQ-007 SHALL have port btn_press, input, 4 bits, meaning a one-cycle press pulse per button; btn_level[i] is 1 from the following cycle.
REQ-008 SHALL have port ev_valid, output, 1 bit, meaning an event is presented.
REQ-009 SHALL have port ev_ready, input, 1 bit, meaning the consumer accepts; transfer occurs when ev_valid & ev_ready.
REQ-010 SHALL have port ev_id, output, 2 bits, meaning the button index of the event.
REQ-011 SHALL have port ev_repeat, output, 1 bit, meaning 0 = initial press and 1 = auto-repeat.
REQ-012 SHALL have port drop_cnt, output, 8 bits, meaning a saturating count of lost events.

Function
REQ-013 SHALL keep, per button, a state in {IDLE, WAIT, REPEAT}, a CW-bit counter cnt, and a one-deep pending slot {pend, pend_rep}.
REQ-014 SHALL, when btn_press[i]=1 in any state, go to WAIT with cnt=0 and generate an event with rep=0; btn_level[i] is ignored that cycle.
REQ-015 SHALL handle WAIT as follows:
- btn_level[i]=0: go to IDLE with cnt=0.
- else if cnt==DELAY-1: generate an event with rep=1 and go to REPEAT with cnt=0.
- else: cnt+1.
REQ-016 SHALL handle REPEAT as follows:
- btn_level[i]=0: go to IDLE with cnt=0.
- else if cnt==PERIOD-1: generate an event with rep=1 and set cnt=0.
- else: cnt+1.
REQ-017 SHALL give release (level 0) priority over event generation when both occur in the same cycle: no event.
REQ-018 SHALL set pend=1 and pend_rep=rep on the next edge for each generated event.
REQ-019 SHALL, if pend[i] is already 1 and is not being drained that cycle, drop the new event, keep the old slot contents, and count a drop.
REQ-020 SHALL load the new event into the slot without a drop if the slot drains in the same cycle.
REQ-021 SHALL load the output register when ev_valid=0 or (ev_valid & ev_ready):
- load the round-robin winner among pend: ev_valid=1, ev_id=winner, ev_repeat=pend_rep[winner];
- clear pend[winner], which counts as the drain;
- if no pend is set: ev_valid=0.
REQ-022 SHALL run the round-robin search from (last_grant+1) mod 4 upward with wrap, and update last_grant only on a load.
REQ-023 SHALL hold ev_valid, ev_id and ev_repeat stable while ev_valid & ~ev_ready.
REQ-024 SHALL have a latency of exactly 2 cycles: press pulse in cycle t -> ev_valid in cycle t+2 when the output register is free.
REQ-025 SHALL increment drop_cnt by the number of drops in the cycle (0-4) and saturate at 255.

Reset
REQ-026 SHALL, while rst=1, immediately force:
- all states to IDLE and all cnt to 0;
- pend=0 and pend_rep=0;
- ev_valid=0, ev_id=0, ev_repeat=0;
- drop_cnt=0 and last_grant=3, so button 0 has first priority.
REQ-027 SHALL generate no events after reset until a new btn_press, even if btn_level stays 1.

Verification (DELAY=8, PERIOD=4, ev_ready=1 unless stated)
REQ-028 SHALL cover: btn_press[0] in cycle 0, level held cycles 1-19, level 0 from cycle 20 -> events (id0) at cycles 2 (rep0), 10, 14 and 18 (rep1); none after.
REQ-029 SHALL cover: btn_press[0] and btn_press[2] both in cycle 0 -> id0 rep0 in cycle 2, id2 rep0 in cycle 3, ev_valid=0 in cycle 4.
REQ-030 SHALL cover: ev_ready=0 with three separate presses of button 1 (released between) -> first in the output register and stable, second pending, third dropped, drop_cnt=1; ev_ready=1 -> two id1 rep0 transfers, then ev_valid=0.
REQ-031 SHALL cover: pend set for buttons 0, 1 and 3 while the output is stalled; then ev_ready=1 -> grant order 0,1,3; a new press of button 0 plus a pending button 1 -> the next grant is 0.
REQ-032 SHALL cover: rst pulsed mid-REPEAT with ev_valid=1 and drop_cnt=5, level kept 1 -> ev_valid=0 and drop_cnt=0 without waiting for a clock edge; no events for 50 cycles.
REQ-033 SHALL cover: 300 forced drops -> drop_cnt stops at 255 with no wrap.
